gc_dispatch: RTL and testbench
==============================

Name: gc_dispatch

Overview:
- Parametrised global-counter dispatcher that hands loop indices to N_CORE cores after a fork.
- Each requesting core gets a unique index gc + k*gd in the same cycle, where k is the number of lower-index cores also granted that cycle.
- Adds an iteration limit with lowest-index-first partial grants, a join state that waits for all cores to end, and reset.
- Sits at top level between the parent core's fork logic and all cores' gc request interfaces.

Parameters:
- N_CORE, 4, number of cores served (≥1).
- GC_WIDTH, 32, width of the counter value.
- GD_WIDTH, 32, width of the signed stride.
- CNT_WIDTH, 16, width of the iteration count.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock; asynchronous, active-low.
- fork_valid  in  1  fork request; sampled only in IDLE.
- fork_gc  in  GC_WIDTH  start value.
- fork_gd  in  GD_WIDTH  signed stride.
- fork_cnt  in  CNT_WIDTH  total indices to hand out (unsigned).
- req_valid  in  N_CORE  per-core request.
- req_ready  out  N_CORE  per-core grant (combinational).
- gc_out  out  N_CORE*GC_WIDTH  per-core value; slice i = bits [i*GC_WIDTH +: GC_WIDTH].
- core_end  in  N_CORE  per-core "finished loop" level.
- busy  out  1  state != IDLE.
- exhausted  out  1  state == JOIN.
- join_pulse  out  1  one-cycle pulse when the join completes.
- fork_err  out  1  sticky: fork_valid seen outside IDLE.

Behaviour:
- Reset (async, rstn=0): state=IDLE; gc=0, gd=0, rem=0, join_pulse=0, fork_err=0. As a result req_ready=0, busy=0 and exhausted=0.
- Prefix: p_i = popcount(req_valid[i-1:0]), with p_0=0.
- req_ready[i] = (state==RUN) && req_valid[i] && (p_i < rem).
  - Lowest-index requesters are granted first.
  - Grant happens the same cycle; there is no latency.
- gc_out[i] = gc + p_i * $signed(gd), truncated to GC_WIDTH with wrap-around (modular).
  - Always driven, grant or not.
  - Only meaningful when req_ready[i]=1.
- granted = min(popcount(req_valid), rem), computed in the RUN state.
- State IDLE:
  - fork_valid=1: load gc←fork_gc, gd←fork_gd, rem←fork_cnt.
  - Next state is JOIN if fork_cnt==0, else RUN.
  - req_valid is ignored in IDLE, including in the fork cycle.
- State RUN:
  - Every cycle: gc←gc+granted*gd, rem←rem−granted.
  - If rem−granted==0, next state is JOIN.
  - With no requests, the state holds.
- State JOIN:
  - No grants.
  - If &core_end==1: join_pulse←1 on the next edge, next state IDLE.
  - core_end is not examined in RUN.
- join_pulse:
  - Registered; high exactly one cycle, which is the first IDLE cycle after the join.
  - A new fork in that cycle is accepted.
- fork_valid in RUN or JOIN: ignored, and fork_err←1.
  - fork_err clears only on reset.
- Reset mid-RUN or mid-JOIN: immediate return to IDLE; pending indices are discarded.
- N_CORE=1: degenerates to a single serial counter.
- Arithmetic is signed for gd; the rem compare is unsigned.

Test Plan:
- Basic: N_CORE=4, fork gc=10, gd=3, cnt=7.
  - Cycle 1, req=1111: ready=1111, gc_out=10,13,16,19.
  - Cycle 2, req=1101 (cores 0,2,3): gc_out0=22, gc_out2=25, gc_out3=28, ready=1101.
  - Then exhausted=1.
- Partial grant: fork gc=0, gd=1, cnt=5.
  - Cycle 1, req=1111: values 0..3.
  - Cycle 2, req=1111: ready=0001, gc_out0=4; cores 1–3 ready=0.
  - Next state JOIN.
- Negative stride: fork gc=100, gd=−4, cnt=3.
  - req=1010: core1=100, core3=96.
  - Next cycle req=0100: core2=92.
  - Then JOIN.
- Join: core_end=1111 held throughout RUN; no join_pulse until JOIN. In JOIN, join_pulse=1 for one cycle and busy→0. With core_end=0111 in JOIN, the state stays JOIN indefinitely.
- Edge cases:
  - Fork with cnt=0: JOIN next cycle, no grants.
  - fork_valid during RUN: gc and rem unchanged, fork_err=1.
  - Wrap: gc=32'hFFFF_FFFE, gd=1 → core0=FFFF_FFFE, core1=FFFF_FFFF, core2=0.
- Reset: assert rstn=0 mid-RUN with rem=50. Outputs go to 0 asynchronously; after release, state is IDLE and a new fork starts cleanly.

Source files
------------

// File: rtl/gc_dispatch.sv
// Global-counter dispatcher: after a fork, hands unique loop indices gc + k*gd to
// requesting cores (lowest index first), then waits in JOIN until every core ends.
module gc_dispatch #(
    parameter int N_CORE    = 4,
    parameter int GC_WIDTH  = 32,
    parameter int GD_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         fork_valid,
    input  logic [GC_WIDTH-1:0]          fork_gc,
    input  logic [GD_WIDTH-1:0]          fork_gd,
    input  logic [CNT_WIDTH-1:0]         fork_cnt,
    input  logic [N_CORE-1:0]            req_valid,
    output logic [N_CORE-1:0]            req_ready,
    output logic [N_CORE*GC_WIDTH-1:0]   gc_out,
    input  logic [N_CORE-1:0]            core_end,
    output logic                         busy,
    output logic                         exhausted,
    output logic                         join_pulse,
    output logic                         fork_err
);

    localparam int PW = $clog2(N_CORE + 1);
    localparam int CW = (PW > CNT_WIDTH) ? PW : CNT_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_JOIN} state_t;

    state_t               state, state_next;
    logic [GC_WIDTH-1:0]  gc;
    logic [GD_WIDTH-1:0]  gd;
    logic [CNT_WIDTH-1:0] rem;
    logic [CNT_WIDTH-1:0] rem_next;
    logic [GC_WIDTH-1:0]  gd_ext;
    logic [PW-1:0]        prefix [N_CORE];
    logic [PW-1:0]        total;
    logic [CW-1:0]        granted;

    // Sign-extending the stride to the counter width makes every product modular in GC_WIDTH.
    assign gd_ext = GC_WIDTH'($signed(gd));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        total = '0;
        for (int i = 0; i < N_CORE; i++) begin
            prefix[i] = total;
            total     = total + PW'(req_valid[i]);
        end
    end

    assign granted  = (CW'(total) < CW'(rem)) ? CW'(total) : CW'(rem);
    assign rem_next = rem - CNT_WIDTH'(granted);

    always_comb begin
        gc_out = '0;
        for (int i = 0; i < N_CORE; i++)
            gc_out[i*GC_WIDTH +: GC_WIDTH] = gc + GC_WIDTH'(prefix[i]) * gd_ext;
    end

    // NOTE: sequential state uses non-blocking assignments and is reset asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (fork_valid) state_next = (fork_cnt == '0) ? S_JOIN : S_RUN;
            S_RUN:  if (rem_next == '0) state_next = S_JOIN;
            S_JOIN: if (&core_end) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        exhausted = (state == S_JOIN);
        req_ready = '0;
        for (int i = 0; i < N_CORE; i++)
            req_ready[i] = (state == S_RUN) && req_valid[i] && (CW'(prefix[i]) < CW'(rem));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gc         <= '0;
            gd         <= '0;
            rem        <= '0;
            join_pulse <= 1'b0;
            fork_err   <= 1'b0;
        end else begin
            join_pulse <= (state == S_JOIN) && (&core_end);
            if (fork_valid && state != S_IDLE) fork_err <= 1'b1;
            case (state)
                S_IDLE: if (fork_valid) begin
                    gc  <= fork_gc;
                    gd  <= fork_gd;
                    rem <= fork_cnt;
                end
                S_RUN: begin
                    gc  <= gc + GC_WIDTH'(granted) * gd_ext;
                    rem <= rem_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gc_dispatch.sv
// Scoreboard bench for gc_dispatch: stimulus pushes expected grants, a negedge monitor
// pops one entry per asserted req_ready and compares core index and value.
module tb_gc_dispatch;

    typedef struct {
        int          core;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fork_valid;
    logic [31:0] fork_gc;
    logic [31:0] fork_gd;
    logic [15:0] fork_cnt;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [127:0] gc_out;
    logic [3:0]  core_end;
    logic        busy, exhausted, join_pulse, fork_err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    gc_dispatch #(.N_CORE(4), .GC_WIDTH(32), .GD_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fork_valid (fork_valid),
        .fork_gc    (fork_gc),
        .fork_gd    (fork_gd),
        .fork_cnt   (fork_cnt),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .gc_out     (gc_out),
        .core_end   (core_end),
        .busy       (busy),
        .exhausted  (exhausted),
        .join_pulse (join_pulse),
        .fork_err   (fork_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int core, input logic [31:0] val);
        exp_t e;
        e.core = core;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic do_fork(input logic [31:0] g, input logic [31:0] d, input logic [15:0] c);
        fork_valid = 1'b1;
        fork_gc    = g;
        fork_gd    = d;
        fork_cnt   = c;
        step();
        fork_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] req);
        req_valid = req;
        step();
        req_valid = '0;
    endtask

    // Monitor: grants must appear in the order the stimulus pushed them (ascending core).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i] === 1'b1) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL grant_unexpected: core %0d granted value %h, expected no grant",
                                 i, gc_out[i*32 +: 32]);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != i || gc_out[i*32 +: 32] !== e.val) begin
                            n_err++;
                            $display("FAIL grant: got core %0d value %h, expected core %0d value %h",
                                     i, gc_out[i*32 +: 32], e.core, e.val);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rstn       = 1'b0;
        fork_valid = 1'b0;
        fork_gc    = '0;
        fork_gd    = '0;
        fork_cnt   = '0;
        req_valid  = '0;
        core_end   = 4'b1111;
        #3;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_exhausted", 32'(exhausted), 32'h0);
        check("rst_join_pulse", 32'(join_pulse), 32'h0);
        check("rst_fork_err", 32'(fork_err), 32'h0);
        step();
        rstn = 1'b1;
        step();

        // Basic, with requests during the fork cycle that must be ignored.
        req_valid = 4'b1111;
        do_fork(32'd10, 32'd3, 16'd7);
        req_valid = '0;
        check("basic_busy", 32'(busy), 32'h1);
        push(0, 32'd10); push(1, 32'd13); push(2, 32'd16); push(3, 32'd19);
        issue(4'b1111);
        check("basic_no_early_pulse", 32'(join_pulse), 32'h0);
        check("basic_not_exhausted", 32'(exhausted), 32'h0);
        push(0, 32'd22); push(2, 32'd25); push(3, 32'd28);
        issue(4'b1101);
        check("basic_exhausted", 32'(exhausted), 32'h1);
        check("basic_join_no_pulse_yet", 32'(join_pulse), 32'h0);
        issue(4'b1111);
        check("basic_join_pulse", 32'(join_pulse), 32'h1);
        check("basic_idle_busy", 32'(busy), 32'h0);
        step();
        check("basic_pulse_one_cycle", 32'(join_pulse), 32'h0);

        // Partial grant, then a JOIN stalled by one core that has not ended.
        core_end = 4'b0111;
        do_fork(32'd0, 32'd1, 16'd5);
        push(0, 32'd0); push(1, 32'd1); push(2, 32'd2); push(3, 32'd3);
        issue(4'b1111);
        push(0, 32'd4);
        issue(4'b1111);
        check("partial_exhausted", 32'(exhausted), 32'h1);
        for (int k = 0; k < 5; k++) step();
        check("join_stall_exhausted", 32'(exhausted), 32'h1);
        check("join_stall_no_pulse", 32'(join_pulse), 32'h0);
        core_end = 4'b1111;
        step();
        check("join_release_pulse", 32'(join_pulse), 32'h1);
        check("join_release_busy", 32'(busy), 32'h0);

        // Negative stride, forked in the join_pulse cycle.
        do_fork(32'd100, -32'sd4, 16'd3);
        check("neg_fork_accepted", 32'(busy), 32'h1);
        push(1, 32'd100); push(3, 32'd96);
        issue(4'b1010);
        push(2, 32'd92);
        issue(4'b0100);
        check("neg_exhausted", 32'(exhausted), 32'h1);
        step();
        step();

        // Zero count goes straight to JOIN with no grants.
        do_fork(32'd5, 32'd1, 16'd0);
        check("cnt0_exhausted", 32'(exhausted), 32'h1);
        issue(4'b1111);
        check("cnt0_idle", 32'(busy), 32'h0);
        step();

        // Fork during RUN is ignored and flagged.
        do_fork(32'd200, 32'd2, 16'd10);
        push(0, 32'd200);
        issue(4'b0001);
        check("ferr_clear_before", 32'(fork_err), 32'h0);
        do_fork(32'd999, 32'd7, 16'd1);
        check("ferr_set", 32'(fork_err), 32'h1);
        check("ferr_still_run", 32'(exhausted), 32'h0);
        push(0, 32'd202); push(1, 32'd204);
        issue(4'b0011);
        push(0, 32'd206); push(1, 32'd208); push(2, 32'd210); push(3, 32'd212);
        issue(4'b1111);
        push(0, 32'd214); push(1, 32'd216); push(2, 32'd218);
        issue(4'b1111);
        check("ferr_run_exhausted", 32'(exhausted), 32'h1);
        step();
        step();

        // Counter wrap-around.
        do_fork(32'hFFFF_FFFE, 32'd1, 16'd3);
        push(0, 32'hFFFF_FFFE); push(1, 32'hFFFF_FFFF); push(2, 32'h0000_0000);
        issue(4'b0111);
        check("wrap_exhausted", 32'(exhausted), 32'h1);
        step();
        step();
        check("ferr_sticky", 32'(fork_err), 32'h1);

        // Asynchronous reset mid-RUN with 50 indices left.
        do_fork(32'd0, 32'd1, 16'd54);
        push(0, 32'd0); push(1, 32'd1); push(2, 32'd2); push(3, 32'd3);
        issue(4'b1111);
        req_valid = 4'b1111;
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_fork_err", 32'(fork_err), 32'h0);
        req_valid = '0;
        step();
        rstn = 1'b1;
        step();
        check("post_rst_idle", 32'(busy), 32'h0);
        do_fork(32'd7, 32'd2, 16'd2);
        push(0, 32'd7); push(1, 32'd9);
        issue(4'b0011);
        check("post_rst_exhausted", 32'(exhausted), 32'h1);
        step();
        step();

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
